// File: rtl/ram8_16_if.sv
// ram8_16_if: data/address/load bus between a RAM8 master and the ram8_16 storage
interface ram8_16_if;
    logic [15:0] i_in;
    logic [2:0]  i_address;
    logic        i_load;
    logic [15:0] o_out;

    modport master (output i_in, output i_address, output i_load, input o_out);
    modport slave  (input i_in, input i_address, input i_load, output o_out);
endinterface

// File: rtl/ram8_16.sv
// ram8_16: 8 x 16-bit Hack RAM8 built structurally from dff bit cells and selectors
module dff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);
    logic r_q;

    // single storage element; synchronous active-low clear wins over data
    always_ff @(posedge i_clk) begin
        r_q <= !i_rst_n ? 1'b0 : i_d;
    end

    assign o_q = r_q;
endmodule

module bit_cell (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_in,
    input  logic i_en,
    output logic o_q
);
    logic w_d;
    logic w_q;

    assign w_d = i_en ? i_in : w_q;

    dff u_dff (.i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(w_d), .o_q(w_q));

    assign o_q = w_q;
endmodule

module register_16 (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_in,
    input  logic        i_en,
    output logic [15:0] o_q
);
    for (genvar g = 0; g < 16; g++) begin : g_bit
        bit_cell u_bit (
            .i_clk  (i_clk),
            .i_rst_n(i_rst_n),
            .i_in   (i_in[g]),
            .i_en   (i_en),
            .o_q    (o_q[g])
        );
    end
endmodule

module dmux8way (
    input  logic       i_in,
    input  logic [2:0] i_sel,
    output logic [7:0] o_out
);
    for (genvar g = 0; g < 8; g++) begin : g_way
        assign o_out[g] = i_in & (i_sel == 3'(g));
    end
endmodule

module mux8way16 (
    input  logic [15:0] i_d [8],
    input  logic [2:0]  i_sel,
    output logic [15:0] o_out
);
    assign o_out = i_d[i_sel];
endmodule

module ram8_16 (
    input  logic      i_clk,
    input  logic      i_rst_n,
    ram8_16_if.slave  bus
);
    logic [7:0]  w_en;
    logic [15:0] w_word [8];

    dmux8way u_dmux (.i_in(bus.i_load), .i_sel(bus.i_address), .o_out(w_en));

    for (genvar g = 0; g < 8; g++) begin : g_word
        register_16 u_reg (
            .i_clk  (i_clk),
            .i_rst_n(i_rst_n),
            .i_in   (bus.i_in),
            .i_en   (w_en[g]),
            .o_q    (w_word[g])
        );
    end

    // read path is purely combinational: no bypass, so a write shows up after the edge
    mux8way16 u_mux (.i_d(w_word), .i_sel(bus.i_address), .o_out(bus.o_out));
endmodule

// File: tb/tb_ram8_16.sv
// tb_ram8_16: directed stimulus for ram8_16 checked against an array memory model
module tb_ram8_16;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] mem [8];
    logic        model_valid = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    ram8_16_if bus ();

    ram8_16 dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: out=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // reference memory: reset clears everything, otherwise the addressed word takes in
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) mem[i] <= 16'h0000;
            model_valid <= 1'b1;
        end else if (bus.i_load) begin
            mem[bus.i_address] <= bus.i_in;
        end
    end

    // every mid-cycle, out must equal the model word at the current address
    always @(negedge clk) begin
        if (model_valid) check("model", bus.o_out, mem[bus.i_address]);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        bus.i_address = a;
        bus.i_in = d;
        bus.i_load = 1'b1;
        step();
        bus.i_load = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string name);
        bus.i_load = 1'b0;
        bus.i_address = a;
        #1;
        check(name, bus.o_out, exp);
        step();
    endtask

    initial begin
        bus.i_in = 16'h0000;
        bus.i_address = 3'd0;
        bus.i_load = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) rd(3'(i), 16'h0000, "reset_initial");

        wr(3'd5, 16'h1234);
        rd(3'd5, 16'h1234, "pre_reset_write");
        rst_n = 1'b0;
        bus.i_load = 1'b1;
        bus.i_in = 16'hFFFF;
        bus.i_address = 3'd5;
        step();
        rst_n = 1'b1;
        bus.i_load = 1'b0;
        for (int i = 0; i < 8; i++) rd(3'(i), 16'h0000, "reset_clear");

        for (int i = 0; i < 8; i++) wr(3'(i), 16'h1000 + 16'(i));
        for (int i = 0; i < 8; i++) begin
            bus.i_address = 3'(i);
            #0;
            check("fill_zero_latency", bus.o_out, 16'h1000 + 16'(i));
        end
        for (int i = 7; i >= 0; i--) rd(3'(i), 16'h1000 + 16'(i), "fill_readback");

        wr(3'd3, 16'hAAAA);
        bus.i_address = 3'd3;
        bus.i_in = 16'h5555;
        bus.i_load = 1'b1;
        #1;
        check("latency_before", bus.o_out, 16'hAAAA);
        step();
        bus.i_load = 1'b0;
        check("latency_after", bus.o_out, 16'h5555);

        wr(3'd7, 16'hFFFF);
        for (int i = 0; i < 20; i++) begin
            bus.i_in = 16'($urandom);
            bus.i_address = 3'(i);
            step();
        end
        rd(3'd7, 16'hFFFF, "hold_addr7");
        rd(3'd3, 16'h5555, "hold_addr3");
        rd(3'd0, 16'h1000, "hold_addr0");
        wr(3'd0, 16'h8000);
        rd(3'd0, 16'h8000, "msb_write");
        rd(3'd1, 16'h1001, "msb_isolation");
        rd(3'd7, 16'hFFFF, "msb_isolation7");

        bus.i_address = 3'd2;
        bus.i_in = 16'hBEEF;
        bus.i_load = 1'b1;
        @(negedge clk);
        #4;
        bus.i_address = 3'd6;
        step();
        bus.i_load = 1'b0;
        rd(3'd6, 16'hBEEF, "addr_switch_word6");
        rd(3'd2, 16'h1002, "addr_switch_word2");

        wr(3'd1, 16'h0101);
        wr(3'd4, 16'h0404);
        wr(3'd1, 16'h1111);
        wr(3'd4, 16'h4444);
        rd(3'd4, 16'h4444, "alt_write4");
        rst_n = 1'b0;
        bus.i_address = 3'd1;
        bus.i_in = 16'h7777;
        bus.i_load = 1'b1;
        step();
        rst_n = 1'b1;
        bus.i_load = 1'b0;
        for (int i = 0; i < 8; i++) rd(3'(i), 16'h0000, "mid_reset_clear");
        wr(3'd4, 16'hC0DE);
        rd(3'd4, 16'hC0DE, "resume_write");
        rd(3'd1, 16'h0000, "resume_other");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ram8_16.md
Name: ram8_16

Overview:
- 8-word x 16-bit register memory (Hack RAM8): the storage stage that consumes the codebase's selector primitives.
- dmux8way steers the load strobe to one of eight 16-bit registers; mux8way16 selects the addressed register onto the output.
- Building block for RAM64/RAM512 and the A/D-register-adjacent data path; it is the first clocked block in the hierarchy.
- Registers are built structurally: dff -> 1-bit register -> 16-bit register -> ram8_16.

Parameters:
- None. Width 16 and depth 8 are fixed by mux8way16/dmux8way.

Ports:
- clk  input  1  single system clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset; sampled on rising edge of clk
- in  input  16  write data
- address  input  3  word select for both read and write
- load  input  1  write enable for the addressed word
- out  output  16  contents of word[address]

Behaviour:
- Reset:
  - Synchronous, active-low. On a rising edge with rst_n=0, all 8 words become 16'h0000.
  - Reset has priority over load; in/address are ignored that cycle.
  - out therefore reads 0 for every address after reset.
  - Reset asserted mid-operation (any load pattern) clears all words at that edge; no partial write survives.
- Write:
  - On a rising edge with rst_n=1 and load=1, word[address] <= in.
  - Exactly one word updates; the other 7 hold.
  - Write decode: dmux8way(load, address) produces per-word enables.
  - Each bit cell holds via mux_gate(q, in, en) feeding dff (dff d = en ? in : q).
- Hold: with rst_n=1 and load=0, all words keep their value indefinitely.
- Read:
  - out = word[address], combinational through mux8way16 from the register outputs (zero-cycle address-to-out latency).
  - Write-to-read latency is one cycle. During the cycle of a write, out shows the old value of word[address].
  - From the edge onward, out shows the new value.
  - No write-through bypass.
- Simultaneous events:
  - load=1 with address changing between edges: only the address sampled at the rising edge is written.
  - Write to word k while reading word j≠k: out is unaffected by the write.
- Initial state before first reset is X.
  - The bench must apply rst_n=0 for at least one edge before checking.
  - The DUT need not model power-on values.
- Widths: no arithmetic. address is exactly 3 bits, so there is no out-of-range case. All 16 data bits are stored verbatim, including 16'hFFFF and 16'h8000.
- Hierarchy:
  - dff: posedge, synchronous active-low clear.
  - bit_cell: mux_gate + dff.
  - register_16: 16 bit_cells sharing the load signal.
  - ram8_16: 8 register_16 + dmux8way + mux8way16.
- Only dff contains an always block; everything above it is structural instances and wires.

Test Plan:
- Reset clear: write 16'h1234 to addr 5, then hold rst_n=0 for 1 edge with load=1, in=16'hFFFF, address=5 -> after edge, out=16'h0000 for all addresses 0..7.
- Fill and read back: after reset, write word i = 16'h1000+i for i=0..7 (one per edge), then sweep address 0..7 with load=0 -> out = 16'h1000..16'h1007 with zero-cycle address latency.
- Write latency: address=3 holds 16'hAAAA; set in=16'h5555, load=1 -> before edge out=16'hAAAA, after edge out=16'h5555.
- Isolation/hold: write 16'hFFFF to addr 7, then 20 cycles of load=0 with random in and address sweeps -> addr 7 still 16'hFFFF, others unchanged; write 16'h8000 to addr 0 -> only addr 0 changes.
- Address change at edge: load=1, in=16'hBEEF, address switches 2->6 just before the edge -> word6=16'hBEEF, word2 unchanged.
- Reset mid-sequence: alternate writes to addr 1 and 4, then drop rst_n for one edge coincident with a write -> all words 0; resumed writes behave normally on the next edge.
